// File: rtl/cv32e40p_alu_arbiter_pkg.sv
// Shared types for the ALU arbiter: the ALU operator encoding of the cv32e40p core
// and the arbiter FSM state.
package cv32e40p_alu_arbiter_pkg;

   localparam int ALU_OP_WIDTH = 7;

   // Encodings match the core's ALU decoder so operators pass through untouched
   typedef enum logic [ALU_OP_WIDTH-1:0] {
      ALU_SLTU = 7'b0000011,
      ALU_AND  = 7'b0010101,
      ALU_ADD  = 7'b0011000,
      ALU_SUB  = 7'b0011001,
      ALU_OR   = 7'b0101110,
      ALU_XOR  = 7'b0101111,
      ALU_DIVU = 7'b0110100,
      ALU_DIV  = 7'b0110101,
      ALU_REMU = 7'b0110110,
      ALU_REM  = 7'b0110111
   } alu_opcode_e;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1,
      ARB_RESP = 2'd2
   } alu_arb_state_e;

endpackage

// File: rtl/cv32e40p_alu_arbiter_if.sv
// Request/response bundle between the requesters and the ALU arbiter.
// Per-requester fields are packed side by side, requester 0 in the low slice.
interface cv32e40p_alu_arbiter_if
   import cv32e40p_alu_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = $clog2(NUM_REQ)
);

   logic [NUM_REQ-1:0]              req_valid_i;
   logic [NUM_REQ-1:0]              req_ready_o;
   logic [NUM_REQ*ALU_OP_WIDTH-1:0] req_op_i;
   logic [NUM_REQ*32-1:0]           req_a_i;
   logic [NUM_REQ*32-1:0]           req_b_i;
   logic [NUM_REQ*32-1:0]           req_c_i;

   logic                            rsp_valid_o;
   logic                            rsp_ready_i;
   logic [ID_W-1:0]                 rsp_id_o;
   logic [31:0]                     rsp_result_o;
   logic                            rsp_cmp_o;
   logic                            rsp_timeout_o;

   modport master (
      output req_valid_i, req_op_i, req_a_i, req_b_i, req_c_i, rsp_ready_i,
      input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_result_o, rsp_cmp_o, rsp_timeout_o
   );

   modport slave (
      input  req_valid_i, req_op_i, req_a_i, req_b_i, req_c_i, rsp_ready_i,
      output req_ready_o, rsp_valid_o, rsp_id_o, rsp_result_o, rsp_cmp_o, rsp_timeout_o
   );

endinterface

// File: rtl/cv32e40p_alu_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid requester after ptr (wrapping),
// returned both one-hot and as an index.
module cv32e40p_alu_arbiter_rr_picker #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 1
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    idx,
   output logic               gnt_any
);

   logic [ID_W-1:0] cand_s;
   logic            hit_s;

   // Scan ptr+1 .. ptr+NUM_REQ and keep only the first hit
   always_comb begin
      grant   = {NUM_REQ{1'b0}};
      idx     = {ID_W{1'b0}};
      gnt_any = 1'b0;
      cand_s  = {ID_W{1'b0}};
      hit_s   = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand_s        = ID_W'((int'(ptr) + i) % NUM_REQ);
         hit_s         = ~gnt_any & valid[cand_s];
         grant[cand_s] = grant[cand_s] | hit_s;
         idx           = hit_s ? cand_s : idx;
         gnt_any       = gnt_any | hit_s;
      end
   end

endmodule

// File: rtl/cv32e40p_alu_arbiter.sv
// Shares one cv32e40p ALU between NUM_REQ requesters: round-robin grant, one op in
// flight, operands held until the ALU is ready, watchdog abort, registered response.
module cv32e40p_alu_arbiter
   import cv32e40p_alu_arbiter_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   cv32e40p_alu_arbiter_if.slave   bus,
   output logic                    alu_enable_o,
   output logic [ALU_OP_WIDTH-1:0] alu_operator_o,
   output logic [31:0]             alu_op_a_o,
   output logic [31:0]             alu_op_b_o,
   output logic [31:0]             alu_op_c_o,
   output logic                    alu_ex_ready_o,
   input  logic [31:0]             alu_result_i,
   input  logic                    alu_cmp_i,
   input  logic                    alu_ready_i
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   alu_arb_state_e          state_r;
   alu_arb_state_e          state_nxt_s;
   logic [ID_W-1:0]         ptr_r;
   logic [ID_W-1:0]         id_r;
   logic [CNT_W-1:0]        cnt_r;
   logic [ALU_OP_WIDTH-1:0] op_r;
   logic [31:0]             a_r;
   logic [31:0]             b_r;
   logic [31:0]             c_r;
   logic [31:0]             result_r;
   logic                    cmp_r;
   logic                    timeout_r;

   logic [NUM_REQ-1:0]      gnt_onehot_s;
   logic [ID_W-1:0]         gnt_idx_s;
   logic                    gnt_any_s;
   logic                    accept_s;
   logic                    done_s;
   logic                    expire_s;

   logic [ALU_OP_WIDTH-1:0] op_arr_s [NUM_REQ];
   logic [31:0]             a_arr_s  [NUM_REQ];
   logic [31:0]             b_arr_s  [NUM_REQ];
   logic [31:0]             c_arr_s  [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign op_arr_s[g] = bus.req_op_i[g*ALU_OP_WIDTH +: ALU_OP_WIDTH];
      assign a_arr_s[g]  = bus.req_a_i[g*32 +: 32];
      assign b_arr_s[g]  = bus.req_b_i[g*32 +: 32];
      assign c_arr_s[g]  = bus.req_c_i[g*32 +: 32];
   end

   cv32e40p_alu_arbiter_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_picker (
      .valid   (bus.req_valid_i),
      .ptr     (ptr_r),
      .grant   (gnt_onehot_s),
      .idx     (gnt_idx_s),
      .gnt_any (gnt_any_s)
   );

   // Next-state and per-cycle event decode
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      done_s      = 1'b0;
      expire_s    = 1'b0;
      case (state_r)
         ARB_IDLE: begin
            if (gnt_any_s) begin
               accept_s    = 1'b1;
               state_nxt_s = ARB_BUSY;
            end else begin
               state_nxt_s = ARB_IDLE;
            end
         end
         ARB_BUSY: begin
            if (alu_ready_i) begin
               done_s      = 1'b1;
               state_nxt_s = ARB_RESP;
            end else if (cnt_r == CNT_LAST) begin
               expire_s    = 1'b1;
               state_nxt_s = ARB_RESP;
            end else begin
               state_nxt_s = ARB_BUSY;
            end
         end
         ARB_RESP: begin
            if (bus.rsp_ready_i) begin
               state_nxt_s = ARB_IDLE;
            end else begin
               state_nxt_s = ARB_RESP;
            end
         end
         default: begin
            state_nxt_s = ARB_IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ARB_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Operation latch, rr pointer, watchdog and response capture
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_r     <= ID_W'(NUM_REQ - 1);
         id_r      <= {ID_W{1'b0}};
         cnt_r     <= {CNT_W{1'b0}};
         op_r      <= {ALU_OP_WIDTH{1'b0}};
         a_r       <= 32'd0;
         b_r       <= 32'd0;
         c_r       <= 32'd0;
         result_r  <= 32'd0;
         cmp_r     <= 1'b0;
         timeout_r <= 1'b0;
      end else begin
         if (accept_s) begin
            ptr_r <= gnt_idx_s;
            id_r  <= gnt_idx_s;
            cnt_r <= {CNT_W{1'b0}};
            op_r  <= op_arr_s[gnt_idx_s];
            a_r   <= a_arr_s[gnt_idx_s];
            b_r   <= b_arr_s[gnt_idx_s];
            c_r   <= c_arr_s[gnt_idx_s];
         end else if ((state_r == ARB_BUSY) && !done_s && !expire_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
         // An aborted op reports zeros so a stale ALU output can never leak out
         if (done_s) begin
            result_r  <= alu_result_i;
            cmp_r     <= alu_cmp_i;
            timeout_r <= 1'b0;
         end else if (expire_s) begin
            result_r  <= 32'd0;
            cmp_r     <= 1'b0;
            timeout_r <= 1'b1;
         end
      end
   end

   assign bus.req_ready_o   = accept_s ? gnt_onehot_s : {NUM_REQ{1'b0}};

   assign alu_enable_o      = (state_r == ARB_BUSY);
   assign alu_ex_ready_o    = (state_r == ARB_BUSY);
   assign alu_operator_o    = op_r;
   assign alu_op_a_o        = a_r;
   assign alu_op_b_o        = b_r;
   assign alu_op_c_o        = c_r;

   assign bus.rsp_valid_o   = (state_r == ARB_RESP);
   assign bus.rsp_id_o      = id_r;
   assign bus.rsp_result_o  = result_r;
   assign bus.rsp_cmp_o     = cmp_r;
   assign bus.rsp_timeout_o = timeout_r;

endmodule

// File: tb/tb_cv32e40p_alu_arbiter.sv
// Directed bench for cv32e40p_alu_arbiter with two requesters and a tiny ALU model
// (ADD / DIVU) whose ready line the bench drives.
module tb_cv32e40p_alu_arbiter;
   import cv32e40p_alu_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_enable;
   logic [6:0]  alu_operator;
   logic [31:0] alu_op_a, alu_op_b, alu_op_c;
   logic        alu_ex_ready;
   logic [31:0] alu_result;
   logic        alu_cmp;
   logic        alu_ready;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   cv32e40p_alu_arbiter_if #(.NUM_REQ(2)) bus ();

   cv32e40p_alu_arbiter #(.NUM_REQ(2), .TIMEOUT_CYC(64)) dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus),
      .alu_enable_o   (alu_enable),
      .alu_operator_o (alu_operator),
      .alu_op_a_o     (alu_op_a),
      .alu_op_b_o     (alu_op_b),
      .alu_op_c_o     (alu_op_c),
      .alu_ex_ready_o (alu_ex_ready),
      .alu_result_i   (alu_result),
      .alu_cmp_i      (alu_cmp),
      .alu_ready_i    (alu_ready)
   );

   always_comb begin
      if (alu_operator == 7'(ALU_DIVU)) begin
         alu_result = (alu_op_b != 32'd0) ? (alu_op_a / alu_op_b) : 32'hFFFF_FFFF;
      end else begin
         alu_result = alu_op_a + alu_op_b;
      end
   end

   task automatic set_req(input int r, input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
      if (r == 0) begin
         bus.req_op_i[6:0]  = op;
         bus.req_a_i[31:0]  = a;
         bus.req_b_i[31:0]  = b;
      end else begin
         bus.req_op_i[13:7] = op;
         bus.req_a_i[63:32] = a;
         bus.req_b_i[63:32] = b;
      end
   endtask

   task automatic test_reset();
      rst             = 1'b1;
      bus.req_valid_i = 2'b00;
      bus.rsp_ready_i = 1'b0;
      bus.req_op_i    = 14'd0;
      bus.req_a_i     = 64'd0;
      bus.req_b_i     = 64'd0;
      bus.req_c_i     = 64'd0;
      alu_ready       = 1'b1;
      alu_cmp         = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      tests_run++;
      if ({alu_operator, alu_op_a, alu_op_b, bus.rsp_id_o, bus.rsp_result_o, bus.rsp_cmp_o, bus.rsp_timeout_o, alu_ex_ready} !== 105'd0) begin
         tests_failed++;
         $display("FAIL reset_values: op=%0h a=%0h id=%0h res=%0h to=%0b expected all 0",
                  alu_operator, alu_op_a, bus.rsp_id_o, bus.rsp_result_o, bus.rsp_timeout_o);
      end
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         tests_run++;
         if ({alu_enable, bus.rsp_valid_o, bus.req_ready_o} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_idle cyc %0d: en/rsp_valid/ready=%b expected 0000", k,
                     {alu_enable, bus.rsp_valid_o, bus.req_ready_o});
         end
      end
   endtask

   task automatic test_single_add();
      @(negedge clk);
      set_req(0, ALU_ADD, 32'd5, 32'd7);
      bus.req_valid_i = 2'b01;
      alu_ready       = 1'b1;
      #1;
      tests_run++;
      if (bus.req_ready_o !== 2'b01) begin
         tests_failed++;
         $display("FAIL add_grant: ready=%b expected 01", bus.req_ready_o);
      end
      @(negedge clk);
      bus.req_valid_i = 2'b00;
      tests_run++;
      if ({alu_enable, alu_ex_ready, alu_operator, alu_op_a, alu_op_b, bus.req_ready_o, bus.rsp_valid_o} !==
          {2'b11, 7'(ALU_ADD), 32'd5, 32'd7, 2'b00, 1'b0}) begin
         tests_failed++;
         $display("FAIL add_busy: en=%b exr=%b op=%0h a=%0d b=%0d ready=%b rv=%b expected 1 1 %0h 5 7 00 0",
                  alu_enable, alu_ex_ready, alu_operator, alu_op_a, alu_op_b, bus.req_ready_o,
                  bus.rsp_valid_o, 7'(ALU_ADD));
      end
      @(negedge clk);
      tests_run++;
      if ({bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_result_o, bus.rsp_cmp_o, bus.rsp_timeout_o, alu_enable} !==
          {1'b1, 1'b0, 32'd12, 1'b1, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL add_rsp: rv=%b id=%0d res=%0d cmp=%b to=%b en=%b expected 1 0 12 1 0 0",
                  bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_result_o, bus.rsp_cmp_o,
                  bus.rsp_timeout_o, alu_enable);
      end
      bus.rsp_ready_i = 1'b1;
      @(negedge clk);
      bus.rsp_ready_i = 1'b0;
      tests_run++;
      if ({bus.rsp_valid_o, alu_enable, alu_operator, alu_op_a} !== {2'b00, 7'(ALU_ADD), 32'd5}) begin
         tests_failed++;
         $display("FAIL add_idle_hold: rv=%b en=%b op=%0h a=%0d expected 0 0 %0h 5",
                  bus.rsp_valid_o, alu_enable, alu_operator, alu_op_a, 7'(ALU_ADD));
      end
   endtask

   task automatic test_round_robin();
      int exp_gnt [4] = '{0, 1, 0, 1};
      int gnt_seen [4] = '{-1, -1, -1, -1};
      int ng = 0;
      int nr = 0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      set_req(0, ALU_ADD, 32'd1, 32'd1);
      set_req(1, ALU_ADD, 32'd10, 32'd20);
      bus.req_valid_i = 2'b11;
      bus.rsp_ready_i = 1'b1;
      alu_ready       = 1'b1;
      for (int cyc = 0; cyc < 40 && nr < 4; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (ng == 4) bus.req_valid_i = 2'b00;
         #1;
         if (bus.req_ready_o != 2'b00 && ng < 4) begin
            gnt_seen[ng] = (bus.req_ready_o == 2'b10) ? 1 : ((bus.req_ready_o == 2'b01) ? 0 : 9);
            ng++;
         end
         if (bus.rsp_valid_o) begin
            tests_run++;
            if ({bus.rsp_id_o, bus.rsp_result_o} !== {nr[0], ((nr % 2) == 1) ? 32'd30 : 32'd2}) begin
               tests_failed++;
               $display("FAIL rr_rsp %0d: id=%0d res=%0d expected id=%0d", nr, bus.rsp_id_o,
                        bus.rsp_result_o, nr % 2);
            end
            nr++;
         end
      end
      tests_run++;
      if (nr != 4) begin
         tests_failed++;
         $display("FAIL rr_rsp_count: got %0d responses expected 4", nr);
      end
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if (gnt_seen[i] != exp_gnt[i]) begin
            tests_failed++;
            $display("FAIL rr_grant %0d: granted %0d expected %0d", i, gnt_seen[i], exp_gnt[i]);
         end
      end
      @(negedge clk);
      bus.rsp_ready_i = 1'b0;
      bus.req_valid_i = 2'b00;
   endtask

   task automatic test_multicycle_div();
      @(negedge clk);
      set_req(1, ALU_DIVU, 32'd100, 32'd7);
      bus.req_valid_i = 2'b10;
      alu_ready       = 1'b0;
      #1;
      tests_run++;
      if (bus.req_ready_o !== 2'b10) begin
         tests_failed++;
         $display("FAIL div_grant: ready=%b expected 10", bus.req_ready_o);
      end
      @(negedge clk);
      bus.req_valid_i = 2'b00;
      for (int k = 0; k < 33; k++) begin
         if (k > 0) @(negedge clk);
         tests_run++;
         if ({alu_enable, alu_operator, alu_op_a, alu_op_b, bus.rsp_valid_o} !==
             {1'b1, 7'(ALU_DIVU), 32'd100, 32'd7, 1'b0}) begin
            tests_failed++;
            $display("FAIL div_hold cyc %0d: en=%b op=%0h a=%0d b=%0d rv=%b expected 1 %0h 100 7 0",
                     k, alu_enable, alu_operator, alu_op_a, alu_op_b, bus.rsp_valid_o, 7'(ALU_DIVU));
         end
      end
      @(negedge clk);
      alu_ready = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_result_o, bus.rsp_timeout_o} !== {1'b1, 1'b1, 32'd14, 1'b0}) begin
         tests_failed++;
         $display("FAIL div_rsp: rv=%b id=%0d res=%0d to=%b expected 1 1 14 0",
                  bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_result_o, bus.rsp_timeout_o);
      end
      bus.rsp_ready_i = 1'b1;
      @(negedge clk);
      bus.rsp_ready_i = 1'b0;
   endtask

   task automatic test_timeout();
      int busy = 0;
      bit done = 1'b0;
      @(negedge clk);
      set_req(0, ALU_ADD, 32'd3, 32'd4);
      bus.req_valid_i = 2'b01;
      alu_ready       = 1'b0;
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge clk);
         if (k == 0) bus.req_valid_i = 2'b00;
         if (bus.rsp_valid_o) done = 1'b1;
         else if (alu_enable) busy++;
      end
      tests_run++;
      if (!done) begin
         tests_failed++;
         $display("FAIL to_rsp_seen: no response within 200 cycles");
      end
      tests_run++;
      if (busy != 64) begin
         tests_failed++;
         $display("FAIL to_busy_cycles: got %0d expected 64", busy);
      end
      tests_run++;
      if ({bus.rsp_timeout_o, bus.rsp_result_o, bus.rsp_cmp_o, bus.rsp_id_o} !== {1'b1, 32'd0, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL to_rsp: to=%b res=%0d cmp=%b id=%0d expected 1 0 0 0",
                  bus.rsp_timeout_o, bus.rsp_result_o, bus.rsp_cmp_o, bus.rsp_id_o);
      end
      bus.rsp_ready_i = 1'b1;
      @(negedge clk);
      bus.rsp_ready_i = 1'b0;
      alu_ready       = 1'b1;
   endtask

   task automatic test_resp_hold();
      @(negedge clk);
      set_req(0, ALU_ADD, 32'd5, 32'd7);
      set_req(1, ALU_ADD, 32'd1, 32'd2);
      bus.req_valid_i = 2'b01;
      alu_ready       = 1'b1;
      @(negedge clk);
      bus.req_valid_i = 2'b10;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         tests_run++;
         if ({bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_result_o, bus.rsp_timeout_o, bus.req_ready_o, alu_enable} !==
             {1'b1, 1'b0, 32'd12, 1'b0, 2'b00, 1'b0}) begin
            tests_failed++;
            $display("FAIL resp_hold cyc %0d: rv=%b id=%0d res=%0d ready=%b en=%b expected 1 0 12 00 0",
                     k, bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_result_o, bus.req_ready_o, alu_enable);
         end
      end
      bus.rsp_ready_i = 1'b1;
      @(negedge clk);
      bus.rsp_ready_i = 1'b0;
      tests_run++;
      if ({bus.rsp_valid_o, bus.req_ready_o} !== 3'b010) begin
         tests_failed++;
         $display("FAIL resp_release: rv=%b ready=%b expected 0 10", bus.rsp_valid_o, bus.req_ready_o);
      end
      bus.req_valid_i = 2'b00;
      @(negedge clk);
      tests_run++;
      if ({alu_enable, bus.req_ready_o, bus.rsp_valid_o} !== 4'b0000) begin
         tests_failed++;
         $display("FAIL withdraw_no_grant: en=%b ready=%b rv=%b expected 0 00 0",
                  alu_enable, bus.req_ready_o, bus.rsp_valid_o);
      end
   endtask

   task automatic test_reset_busy();
      @(negedge clk);
      set_req(0, ALU_ADD, 32'd9, 32'd9);
      bus.req_valid_i = 2'b01;
      alu_ready       = 1'b0;
      @(negedge clk);
      bus.req_valid_i = 2'b00;
      tests_run++;
      if (alu_enable !== 1'b1) begin
         tests_failed++;
         $display("FAIL rstbusy_enter: en=%b expected 1", alu_enable);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tests_run++;
      if ({alu_enable, alu_ex_ready, bus.rsp_valid_o, bus.req_ready_o, alu_operator, alu_op_a} !== 44'd0) begin
         tests_failed++;
         $display("FAIL rstbusy_clear: en=%b rv=%b op=%0h a=%0d expected all 0",
                  alu_enable, bus.rsp_valid_o, alu_operator, alu_op_a);
      end
      alu_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         tests_run++;
         if ({bus.rsp_valid_o, alu_enable} !== 2'b00) begin
            tests_failed++;
            $display("FAIL rstbusy_no_rsp cyc %0d: rv=%b en=%b expected 0 0", k, bus.rsp_valid_o, alu_enable);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_round_robin();
      test_multicycle_div();
      test_timeout();
      test_resp_hold();
      test_reset_busy();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
